// File: rtl/pc_predict.sv
// Program counter and direct-mapped branch target buffer for the fetch stage.
// Chooses the next fetch address and trains 2-bit saturating counters on resolved branches.
module pc_predict #(
    parameter int          IDX_W      = 3,
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] INT_VECTOR = 16'h0008
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall_pc_i,
    input  logic        isintzero_i,
    input  logic        jr_i,
    input  logic [15:0] jr_target_i,
    input  logic        prewrong_i,
    input  logic        precorrc_i,
    input  logic [15:0] br_pc_i,
    input  logic        br_taken_i,
    input  logic [15:0] br_target_i,
    output logic [15:0] pc_o,
    output logic [15:0] pc_plus1_o,
    output logic        prediction_o,
    output logic [15:0] pred_target_o
);

    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = 16 - IDX_W;

    logic [15:0]      pc_q, pc_d;
    logic [N-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0] tag_q    [N];
    logic [TAG_W-1:0] tag_d    [N];
    logic [15:0]      target_q [N];
    logic [15:0]      target_d [N];
    logic [1:0]       cnt_q    [N];
    logic [1:0]       cnt_d    [N];

    logic [IDX_W-1:0] lk_idx;
    logic             lk_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_en;
    logic             upd_hit;

    assign lk_idx        = pc_q[IDX_W-1:0];
    assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == pc_q[15:IDX_W]);
    assign prediction_o  = lk_hit && cnt_q[lk_idx][1];
    assign pred_target_o = lk_hit ? target_q[lk_idx] : 16'h0000;
    assign pc_o          = pc_q;
    assign pc_plus1_o    = pc_q + 16'd1;

    assign upd_idx = br_pc_i[IDX_W-1:0];
    assign upd_tag = br_pc_i[15:IDX_W];
    assign upd_en  = (prewrong_i || precorrc_i) && !isintzero_i;
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        pc_d = pc_q + 16'd1;
        if (isintzero_i)       pc_d = INT_VECTOR;
        else if (stall_pc_i)   pc_d = pc_q;
        else if (prewrong_i)   pc_d = br_taken_i ? br_target_i : br_pc_i + 16'd1;
        else if (jr_i)         pc_d = jr_target_i;
        else if (prediction_o) pc_d = pred_target_o;
    end

    // Lookup uses the registered entry, so a same-cycle update is only seen next cycle.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (upd_en) begin
            if (upd_hit) begin
                if (br_taken_i) begin
                    cnt_d[upd_idx]    = (cnt_q[upd_idx] == 2'b11) ? 2'b11 : cnt_q[upd_idx] + 2'd1;
                    target_d[upd_idx] = br_target_i;
                end else begin
                    cnt_d[upd_idx]    = (cnt_q[upd_idx] == 2'b00) ? 2'b00 : cnt_q[upd_idx] - 2'd1;
                end
            end else if (br_taken_i) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = br_target_i;
                cnt_d[upd_idx]    = 2'b10;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
            for (int i = 0; i < N; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
        end else begin
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_predict.sv
// Bench for pc_predict: directed scenarios plus random traffic, all checked
// against an array-based model of the PC and BTB rules.
module tb_pc_predict;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        stall_pc_i = 1'b0, isintzero_i = 1'b0, jr_i = 1'b0;
    logic [15:0] jr_target_i = '0;
    logic        prewrong_i = 1'b0, precorrc_i = 1'b0;
    logic [15:0] br_pc_i = '0;
    logic        br_taken_i = 1'b0;
    logic [15:0] br_target_i = '0;
    logic [15:0] pc_o, pc_plus1_o, pred_target_o;
    logic        prediction_o;

    int num_checks = 0;
    int num_passed = 0;

    // Reference state: plain integers, index = pc mod 8, tag = pc / 8.
    int m_pc;
    int m_valid [8];
    int m_tag   [8];
    int m_tgt   [8];
    int m_cnt   [8];

    pc_predict dut (
        .CLK(CLK), .RST(RST),
        .stall_pc_i(stall_pc_i), .isintzero_i(isintzero_i),
        .jr_i(jr_i), .jr_target_i(jr_target_i),
        .prewrong_i(prewrong_i), .precorrc_i(precorrc_i),
        .br_pc_i(br_pc_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .pc_o(pc_o), .pc_plus1_o(pc_plus1_o),
        .prediction_o(prediction_o), .pred_target_o(pred_target_o)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        num_checks++;
        if (actual === expected) num_passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    function automatic void model_reset();
        m_pc = 0;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
        end
    endfunction

    function automatic int model_hit(input int pc);
        return (m_valid[pc % 8] != 0 && m_tag[pc % 8] == pc / 8) ? 1 : 0;
    endfunction

    function automatic int model_pred(input int pc);
        return (model_hit(pc) != 0 && m_cnt[pc % 8] >= 2) ? 1 : 0;
    endfunction

    function automatic int model_ptgt(input int pc);
        return (model_hit(pc) != 0) ? m_tgt[pc % 8] : 0;
    endfunction

    // Drive one cycle of inputs, check current outputs, advance the model across the edge.
    task automatic applyStimulus(input logic st, input logic itz, input logic jr, input logic [15:0] jrt,
                                 input logic pw, input logic pc_ok, input logic [15:0] bpc,
                                 input logic tk, input logic [15:0] btgt);
        int nxt, bi, bt;
        stall_pc_i = st; isintzero_i = itz; jr_i = jr; jr_target_i = jrt;
        prewrong_i = pw; precorrc_i = pc_ok; br_pc_i = bpc; br_taken_i = tk; br_target_i = btgt;
        #1;
        checkOutput("pc_o", pc_o, 16'(m_pc));
        checkOutput("pc_plus1_o", pc_plus1_o, 16'((m_pc + 1) % 65536));
        checkOutput("prediction_o", {15'b0, prediction_o}, 16'(model_pred(m_pc)));
        checkOutput("pred_target_o", pred_target_o, 16'(model_ptgt(m_pc)));
        if (itz)                       nxt = 16'h0008;
        else if (st)                   nxt = m_pc;
        else if (pw)                   nxt = tk ? int'(btgt) : (int'(bpc) + 1) % 65536;
        else if (jr)                   nxt = int'(jrt);
        else if (model_pred(m_pc) != 0) nxt = model_ptgt(m_pc);
        else                           nxt = (m_pc + 1) % 65536;
        @(posedge CLK);
        #1;
        m_pc = nxt;
        if ((pw || pc_ok) && !itz) begin
            bi = int'(bpc) % 8;
            bt = int'(bpc) / 8;
            if (m_valid[bi] != 0 && m_tag[bi] == bt) begin
                if (tk) begin
                    m_cnt[bi] = (m_cnt[bi] + 1 > 3) ? 3 : m_cnt[bi] + 1;
                    m_tgt[bi] = int'(btgt);
                end else begin
                    m_cnt[bi] = (m_cnt[bi] - 1 < 0) ? 0 : m_cnt[bi] - 1;
                end
            end else if (tk) begin
                m_valid[bi] = 1; m_tag[bi] = bt; m_tgt[bi] = int'(btgt); m_cnt[bi] = 2;
            end
        end
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
    endtask

    task automatic jump(input logic [15:0] t);
        applyStimulus(0, 0, 1, t, 0, 0, 16'h0, 0, 16'h0);
    endtask

    initial begin
        model_reset();
        #3;
        checkOutput("reset pc_o", pc_o, 16'h0000);
        checkOutput("reset prediction_o", {15'b0, prediction_o}, 16'h0000);
        checkOutput("reset pred_target_o", pred_target_o, 16'h0000);
        @(posedge CLK); #1;
        RST = 1'b1;

        // Sequential fetch and wrap-around
        repeat (4) idle();
        checkOutput("seq pc after 4", pc_o, 16'h0004);
        jump(16'hFFFF);
        idle();
        checkOutput("wrap pc", pc_o, 16'h0000);

        // Mispredict install, then predicted fetch
        jump(16'h0005);
        applyStimulus(0, 0, 0, 16'h0, 1, 0, 16'h0002, 1, 16'h0040);
        checkOutput("mispredict redirect", pc_o, 16'h0040);
        jump(16'h0002);
        checkOutput("installed prediction", {15'b0, prediction_o}, 16'h0001);
        checkOutput("installed target", pred_target_o, 16'h0040);
        idle();
        checkOutput("predicted redirect", pc_o, 16'h0040);

        // Counter saturation and decay
        repeat (3) applyStimulus(0, 0, 0, 16'h0, 0, 1, 16'h0002, 1, 16'h0040);
        applyStimulus(0, 0, 0, 16'h0, 1, 0, 16'h0002, 0, 16'h0);
        checkOutput("not-taken redirect", pc_o, 16'h0003);
        jump(16'h0002);
        checkOutput("cnt 10 still taken", {15'b0, prediction_o}, 16'h0001);
        applyStimulus(0, 0, 0, 16'h0, 1, 0, 16'h0002, 0, 16'h0);
        jump(16'h0002);
        checkOutput("cnt 01 not taken", {15'b0, prediction_o}, 16'h0000);

        // Tag alias replacement
        applyStimulus(0, 0, 0, 16'h0, 1, 0, 16'h0002, 1, 16'h0040);
        jump(16'h000A);
        checkOutput("alias miss", {15'b0, prediction_o}, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0, 1, 0, 16'h000A, 1, 16'h0100);
        checkOutput("alias redirect", pc_o, 16'h0100);
        jump(16'h000A);
        checkOutput("alias new target", pred_target_o, 16'h0100);
        jump(16'h0002);
        checkOutput("replaced entry miss", {15'b0, prediction_o}, 16'h0000);

        // Next-PC priority
        applyStimulus(1, 1, 1, 16'h0077, 1, 0, 16'h0003, 1, 16'h0055);
        checkOutput("interrupt wins", pc_o, 16'h0008);
        jump(16'h0003);
        checkOutput("btb unchanged on int", {15'b0, prediction_o}, 16'h0000);
        jump(16'h0008);
        applyStimulus(1, 0, 1, 16'h0077, 0, 0, 16'h0, 0, 16'h0);
        checkOutput("stall beats jr", pc_o, 16'h0008);
        applyStimulus(0, 0, 1, 16'h0077, 1, 0, 16'h0020, 1, 16'h0030);
        checkOutput("prewrong beats jr", pc_o, 16'h0030);

        // Asynchronous reset between edges
        jump(16'h0040);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checkOutput("async reset pc", pc_o, 16'h0000);
        model_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        jump(16'h000A);
        checkOutput("post-reset miss A", {15'b0, prediction_o}, 16'h0000);
        jump(16'h0020);
        checkOutput("post-reset miss 20", {15'b0, prediction_o}, 16'h0000);

        // Random traffic confined to a small address window so the BTB gets hits
        for (int n = 0; n < 400; n++) begin
            logic st, itz, jr, pw, pco, tk;
            int r;
            st  = ($urandom_range(0, 99) < 10);
            itz = ($urandom_range(0, 99) < 4);
            jr  = ($urandom_range(0, 99) < 25);
            r   = $urandom_range(0, 99);
            pw  = (r < 25) || (r >= 95);
            pco = (r >= 25 && r < 50) || (r >= 95);
            tk  = $urandom_range(0, 1) == 1;
            applyStimulus(st, itz, jr, 16'($urandom_range(0, 23)), pw, pco,
                          16'($urandom_range(0, 23)), tk, 16'($urandom_range(0, 23)));
        end

        $display("%0d/%0d checks passed", num_passed, num_checks);
        $finish;
    end

endmodule
